// File: rtl/coin_front_end_if.sv
// Bundle between customer inputs / vending core and coin_front_end.
// master drives pulses, selection and core status; slave (the front end) drives the order and refund.
interface coin_front_end_if;
    logic       coin5_pulse;
    logic       coin1_pulse;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic [1:0] service_type;
    logic [1:0] coinInNTD_5;
    logic [1:0] coinInNTD_1;
    logic [1:0] itemTypeIn;
    logic       coin_reject;
    logic       refund_valid;
    logic [1:0] refund_5;
    logic [1:0] refund_1;
    logic [3:0] credit;
    logic       busy;

    modport master (
        output coin5_pulse, coin1_pulse, sel_valid, sel_item, cancel, service_type,
        input  coinInNTD_5, coinInNTD_1, itemTypeIn, coin_reject, refund_valid,
               refund_5, refund_1, credit, busy
    );

    modport slave (
        input  coin5_pulse, coin1_pulse, sel_valid, sel_item, cancel, service_type,
        output coinInNTD_5, coinInNTD_1, itemTypeIn, coin_reject, refund_valid,
               refund_5, refund_1, credit, busy
    );
endinterface

// File: rtl/coin_front_end.sv
// Coin/selection collector ahead of the vending core; all outputs registered (1-cycle latency).
// Holds an issued order stable until the core samples it with SERVICE_ON; excess coins are rejected.
module coin_front_end #(
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    coin_front_end_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam logic [1:0] S_WAIT    = 2'd3;

    localparam logic [1:0] ITEM_NONE = 2'd0;
    localparam logic [1:0] SVC_OFF   = 2'd0;
    localparam logic [1:0] SVC_ON    = 2'd1;

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]      state_q, state_d;
    logic [1:0]      cnt5_q, cnt5_d;
    logic [1:0]      cnt1_q, cnt1_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [1:0]      out5_q, out5_d;
    logic [1:0]      out1_q, out1_d;
    logic [1:0]      item_q, item_d;
    logic            reject_q, reject_d;
    logic            refund_vld_q, refund_vld_d;
    logic [1:0]      refund5_q, refund5_d;
    logic [1:0]      refund1_q, refund1_d;
    logic [3:0]      credit_q, credit_d;
    logic            busy_q, busy_d;

    logic       any_coin;
    logic       activity;
    logic       full5, full1;
    logic [1:0] acc5, acc1;

    // Saturating counts as they would stand if this cycle's coins were accepted.
    always_comb begin
        any_coin = bus.coin5_pulse | bus.coin1_pulse;
        activity = any_coin | bus.sel_valid | bus.cancel;
        full5    = bus.coin5_pulse && (cnt5_q == 2'd3);
        full1    = bus.coin1_pulse && (cnt1_q == 2'd3);
        acc5     = (bus.coin5_pulse && !full5) ? cnt5_q + 2'd1 : cnt5_q;
        acc1     = (bus.coin1_pulse && !full1) ? cnt1_q + 2'd1 : cnt1_q;
    end

    always_comb begin
        state_d      = state_q;
        cnt5_d       = cnt5_q;
        cnt1_d       = cnt1_q;
        timer_d      = '0;
        out5_d       = out5_q;
        out1_d       = out1_q;
        item_d       = item_q;
        reject_d     = 1'b0;
        refund_vld_d = 1'b0;
        refund5_d    = 2'd0;
        refund1_d    = 2'd0;

        case (state_q)
            S_IDLE: begin
                out5_d = 2'd0;
                out1_d = 2'd0;
                item_d = ITEM_NONE;
                if (any_coin) begin
                    cnt5_d  = acc5;
                    cnt1_d  = acc1;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.cancel || (!activity && timer_q == TIMER_LAST)) begin
                    // Coins landing in the refund decision cycle are bounced, not counted.
                    refund_vld_d = 1'b1;
                    refund5_d    = cnt5_q;
                    refund1_d    = cnt1_q;
                    cnt5_d       = 2'd0;
                    cnt1_d       = 2'd0;
                    reject_d     = any_coin;
                    state_d      = S_IDLE;
                end else begin
                    cnt5_d   = acc5;
                    cnt1_d   = acc1;
                    reject_d = full5 | full1;
                    timer_d  = activity ? '0 : timer_q + TO_W'(1);
                    if (bus.sel_valid && bus.sel_item != ITEM_NONE) begin
                        out5_d  = acc5;
                        out1_d  = acc1;
                        item_d  = bus.sel_item;
                        timer_d = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                reject_d = any_coin;
                if (bus.service_type == SVC_ON) begin
                    out5_d  = 2'd0;
                    out1_d  = 2'd0;
                    item_d  = ITEM_NONE;
                    cnt5_d  = 2'd0;
                    cnt1_d  = 2'd0;
                    state_d = S_WAIT;
                end
            end
            default: begin
                reject_d = any_coin;
                if (bus.service_type == SVC_OFF) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        busy_d   = (state_d == S_ISSUE) || (state_d == S_WAIT);
        credit_d = ({2'b00, cnt5_q} * 4'd3) + {2'b00, cnt1_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt5_q       <= 2'd0;
            cnt1_q       <= 2'd0;
            timer_q      <= '0;
            out5_q       <= 2'd0;
            out1_q       <= 2'd0;
            item_q       <= ITEM_NONE;
            reject_q     <= 1'b0;
            refund_vld_q <= 1'b0;
            refund5_q    <= 2'd0;
            refund1_q    <= 2'd0;
            credit_q     <= 4'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt5_q       <= cnt5_d;
            cnt1_q       <= cnt1_d;
            timer_q      <= timer_d;
            out5_q       <= out5_d;
            out1_q       <= out1_d;
            item_q       <= item_d;
            reject_q     <= reject_d;
            refund_vld_q <= refund_vld_d;
            refund5_q    <= refund5_d;
            refund1_q    <= refund1_d;
            credit_q     <= credit_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.coinInNTD_5  = out5_q;
    assign bus.coinInNTD_1  = out1_q;
    assign bus.itemTypeIn   = item_q;
    assign bus.coin_reject  = reject_q;
    assign bus.refund_valid = refund_vld_q;
    assign bus.refund_5     = refund5_q;
    assign bus.refund_1     = refund1_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_coin_front_end.sv
// Directed bench for coin_front_end: order issue, handshake with core, saturation, cancel, timeout, reset.
module tb_coin_front_end;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    coin_front_end_if bus();

    coin_front_end #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of pulse inputs, take the edge, then sample 1 time unit later.
    task automatic step(input logic c5, input logic c1, input logic sv,
                        input logic [1:0] item, input logic cn);
        bus.coin5_pulse = c5;
        bus.coin1_pulse = c1;
        bus.sel_valid   = sv;
        bus.sel_item    = item;
        bus.cancel      = cn;
        @(posedge clk);
        #1;
        bus.coin5_pulse = 1'b0;
        bus.coin1_pulse = 1'b0;
        bus.sel_valid   = 1'b0;
        bus.sel_item    = 2'd0;
        bus.cancel      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'd0, 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.coin5_pulse  = 1'b0;
        bus.coin1_pulse  = 1'b0;
        bus.sel_valid    = 1'b0;
        bus.sel_item     = 2'd0;
        bus.cancel       = 1'b0;
        bus.service_type = 2'd0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;

        chk("rst_out5",   bus.coinInNTD_5, 0);
        chk("rst_out1",   bus.coinInNTD_1, 0);
        chk("rst_item",   bus.itemTypeIn, 0);
        chk("rst_reject", bus.coin_reject, 0);
        chk("rst_refund", bus.refund_valid, 0);
        chk("rst_credit", bus.credit, 0);
        chk("rst_busy",   bus.busy, 0);

        // Order: 2x NTD5, 1x NTD1, item A.
        step(1, 0, 0, 2'd0, 0);
        chk("credit_lag0", bus.credit, 0);
        step(1, 0, 0, 2'd0, 0);
        chk("credit_3", bus.credit, 3);
        step(0, 1, 0, 2'd0, 0);
        chk("credit_6", bus.credit, 6);
        bus.service_type = 2'd2;
        step(0, 0, 1, 2'd1, 0);
        chk("issue_out5", bus.coinInNTD_5, 2);
        chk("issue_out1", bus.coinInNTD_1, 1);
        chk("issue_item", bus.itemTypeIn, 1);
        chk("issue_busy", bus.busy, 1);
        chk("issue_credit", bus.credit, 7);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 2'd0, 0);
            chk("hold_out5", bus.coinInNTD_5, 2);
            chk("hold_item", bus.itemTypeIn, 1);
        end
        bus.service_type = 2'd1;
        step(0, 0, 0, 2'd0, 0);
        bus.service_type = 2'd2;
        chk("wait_out5", bus.coinInNTD_5, 0);
        chk("wait_out1", bus.coinInNTD_1, 0);
        chk("wait_item", bus.itemTypeIn, 0);
        chk("wait_busy", bus.busy, 1);
        step(0, 1, 0, 2'd0, 0);
        chk("wait_coin_reject", bus.coin_reject, 1);
        chk("wait_credit0", bus.credit, 0);
        bus.service_type = 2'd0;
        step(0, 0, 0, 2'd0, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_no_reject", bus.coin_reject, 0);

        // Saturate NTD1, then cancel with a stray coin5 in the cancel cycle.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 2'd0, 0);
            chk("sat_no_reject", bus.coin_reject, 0);
        end
        step(0, 1, 0, 2'd0, 0);
        chk("sat_reject", bus.coin_reject, 1);
        step(0, 0, 0, 2'd0, 0);
        chk("sat_reject_pulse", bus.coin_reject, 0);
        chk("sat_credit", bus.credit, 3);
        step(1, 0, 0, 2'd0, 1);
        chk("cancel_vld", bus.refund_valid, 1);
        chk("cancel_r1", bus.refund_1, 3);
        chk("cancel_r5", bus.refund_5, 0);
        chk("cancel_reject", bus.coin_reject, 1);
        chk("cancel_busy", bus.busy, 0);
        step(0, 0, 0, 2'd0, 0);
        chk("cancel_vld_pulse", bus.refund_valid, 0);
        chk("cancel_r1_clr", bus.refund_1, 0);
        chk("cancel_credit0", bus.credit, 0);

        // Inactivity timeout.
        step(1, 0, 0, 2'd0, 0);
        idle(15);
        chk("to_not_yet", bus.refund_valid, 0);
        step(0, 0, 0, 2'd0, 0);
        chk("to_vld", bus.refund_valid, 1);
        chk("to_r5", bus.refund_5, 1);
        chk("to_r1", bus.refund_1, 0);
        step(0, 0, 0, 2'd0, 0);
        chk("to_credit0", bus.credit, 0);
        chk("to_vld_pulse", bus.refund_valid, 0);
        // Still IDLE: a selection alone must not issue.
        step(0, 0, 1, 2'd3, 0);
        chk("to_idle_busy", bus.busy, 0);

        // Coins with sel C while IDLE: selection ignored, coins counted.
        bus.service_type = 2'd2;
        step(1, 1, 1, 2'd3, 0);
        chk("idle_sel_busy", bus.busy, 0);
        chk("idle_sel_item", bus.itemTypeIn, 0);
        step(0, 0, 1, 2'd0, 0);
        chk("sel_none_busy", bus.busy, 0);
        step(0, 1, 1, 2'd3, 0);
        chk("samecyc_out5", bus.coinInNTD_5, 1);
        chk("samecyc_out1", bus.coinInNTD_1, 2);
        chk("samecyc_item", bus.itemTypeIn, 3);
        step(1, 0, 0, 2'd0, 1);
        chk("issue_coin_reject", bus.coin_reject, 1);
        chk("issue_no_cancel", bus.refund_valid, 0);
        chk("issue_hold5", bus.coinInNTD_5, 1);

        // Reset in ISSUE discards everything silently.
        reset = 1'b1;
        step(0, 0, 0, 2'd0, 0);
        reset = 1'b0;
        bus.service_type = 2'd0;
        chk("midrst_out5", bus.coinInNTD_5, 0);
        chk("midrst_out1", bus.coinInNTD_1, 0);
        chk("midrst_item", bus.itemTypeIn, 0);
        chk("midrst_refund", bus.refund_valid, 0);
        chk("midrst_credit", bus.credit, 0);
        chk("midrst_busy", bus.busy, 0);
        step(0, 0, 1, 2'd1, 0);
        chk("zero_sel_busy", bus.busy, 0);
        chk("zero_sel_item", bus.itemTypeIn, 0);
        step(0, 0, 0, 2'd0, 1);
        chk("zero_cancel", bus.refund_valid, 0);
        step(0, 0, 0, 2'd0, 0);
        chk("zero_credit", bus.credit, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
